// File: rtl/pixel_doubler_upscaler_if.sv
// Pixel stream bundle: valid/ready handshake with start-of-frame and end-of-line markers.
// The master drives the pixel and its markers, and the slave returns ready.
interface pixel_doubler_upscaler_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  sof;
    logic                  eol;

    modport master (output valid, data, sof, eol, input ready);
    modport slave  (input valid, data, sof, eol, output ready);
endinterface

// File: rtl/pixel_doubler_upscaler.sv
// 2x nearest-neighbour stream upscaler: each pixel is emitted twice, and each line is replayed once from a line buffer.
// Optional UPSCALE_STATS_EN adds frame_cnt (wrapping) and err_cnt (saturating) status outputs.
module pixel_doubler_upscaler #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_WIDTH   = 960,
    parameter int IN_HEIGHT  = 540
) (
    input  logic clk,
    input  logic rst_n,
    pixel_doubler_upscaler_if.slave  in_stream,
    pixel_doubler_upscaler_if.master out_stream,
    output logic frame_done,
    output logic proto_err
`ifdef UPSCALE_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam int XW = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
    localparam int YW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int RW = XW + 1;

    localparam logic [XW-1:0] X_LAST = XW'(IN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IN_HEIGHT - 1);
    localparam logic [RW-1:0] R_LAST = RW'(2 * IN_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LIVE_A,
        LIVE_B,
        FETCH,
        REPLAY,
        WAIT_LINE
    } state_t;

    state_t                state;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [RW-1:0]         r;
    logic [DATA_WIDTH-1:0] line_buf [IN_WIDTH];

    // out_data also serves as the pixel hold register during live beats.
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sof;
    logic                  out_eol;

    logic          in_ready_c;
    logic          accept, restart, advance, line_start, drop, store;
    logic          eol_err, sof_err, err_evt;
    logic [XW-1:0] new_x;
    logic [RW-1:0] r_next;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        in_ready_c = 1'b0;
        case (state)
            IDLE, FETCH, WAIT_LINE: in_ready_c = 1'b1;
            LIVE_B:                 in_ready_c = out_stream.ready && (x != X_LAST);
            default:                in_ready_c = 1'b0;
        endcase
    end

    assign in_stream.ready = rst_n & in_ready_c;

    assign accept     = in_stream.valid & in_stream.ready;
    assign restart    = accept & in_stream.sof;
    assign advance    = accept & ~in_stream.sof & ((state == LIVE_B) || (state == FETCH));
    assign line_start = accept & ~in_stream.sof & (state == WAIT_LINE);
    assign drop       = accept & ~in_stream.sof & (state == IDLE);
    assign store      = restart | advance | line_start;
    assign new_x      = advance ? x + 1'b1 : '0;
    assign r_next     = r + 1'b1;

    // Line length is set by the counter alone; in_eol is only checked against it.
    assign eol_err = store & (in_stream.eol != (new_x == X_LAST));
    assign sof_err = restart & (state != IDLE);
    assign err_evt = drop | sof_err | eol_err;

    assign out_stream.valid = out_valid;
    assign out_stream.data  = out_data;
    assign out_stream.sof   = out_sof;
    assign out_stream.eol   = out_eol;

    // NOTE: the line buffer has no reset; every entry is written before a replay reads it.
    always_ff @(posedge clk) begin
        if (store) line_buf[new_x] <= in_stream.data;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            r          <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (err_evt) proto_err <= 1'b1;

            if (store) begin
                // A pixel with sof always restarts the frame, even if that abandons a partial line.
                state     <= LIVE_A;
                x         <= new_x;
                if (restart) y <= '0;
                out_valid <= 1'b1;
                out_data  <= in_stream.data;
                out_sof   <= restart;
                out_eol   <= 1'b0;
            end else begin
                case (state)
                    LIVE_A: begin
                        if (out_stream.ready) begin
                            state   <= LIVE_B;
                            out_sof <= 1'b0;
                            out_eol <= (x == X_LAST);
                        end
                    end
                    LIVE_B: begin
                        if (out_stream.ready) begin
                            out_eol <= 1'b0;
                            if (x == X_LAST) begin
                                state    <= REPLAY;
                                r        <= '0;
                                out_data <= line_buf[0];
                            end else begin
                                state     <= FETCH;
                                out_valid <= 1'b0;
                            end
                        end
                    end
                    REPLAY: begin
                        if (out_stream.ready) begin
                            if (r == R_LAST) begin
                                out_valid <= 1'b0;
                                out_eol   <= 1'b0;
                                if (y == Y_LAST) begin
                                    state      <= IDLE;
                                    frame_done <= 1'b1;
                                end else begin
                                    y     <= y + 1'b1;
                                    state <= WAIT_LINE;
                                end
                            end else begin
                                r        <= r_next;
                                out_data <= line_buf[r_next[RW-1:1]];
                                out_eol  <= (r_next == R_LAST);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef UPSCALE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (frame_done) frame_cnt <= frame_cnt + 1'b1;
            if (err_evt && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule
